// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared types and constants for the memory-stage SRAM controller.
//   mem_state_t      : access sequencer states (IDLE, LO, HI, DONE)
//   MEM_BASE_DEFAULT : byte address that maps to SRAM word 0
//   HALF_LO/HALF_HI  : half-word select bit appended to the word index
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned MEM_BASE_DEFAULT = 1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt
// Loadable down-counter that times one SRAM half-access.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : reload the counter with load_val (state entry)
//   load_val  : number of extra wait cycles to count
//   done      : high while the count is zero (last cycle of the half-access)
module sram_wait_cnt #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Count down to zero and park there; a load always wins so that back-to-back
  // half-accesses each get a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_ONE;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// Memory stage of the ARM pipeline. A 32-bit load or store from the EXE/MEM
// register is carried out as two 16-bit accesses to an external SRAM (low
// half first), while ready is held low to freeze the upstream pipeline.
// Optional feature macro: MEM_ALIGN_CHECK_EN (alignment / range checking with
// an addr_err pulse; without it addresses wrap modulo the SRAM size).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   MEM_R_EN_in       : load request
//   MEM_W_EN_in       : store request (wins when both enables are set)
//   ALU_result_in     : byte address
//   ST_val_in         : store data
//   ready             : 1 = pipeline may advance, 0 = freeze
//   mem_read_data     : last loaded word, held through stores and idle cycles
//   sram_addr         : SRAM half-word address
//   sram_wdata        : SRAM write half
//   sram_rdata        : SRAM read half
//   sram_we_n         : SRAM write enable, active-low
//   addr_err          : one-cycle pulse on a rejected request
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MEM_BASE    = MEM_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN_in,
  input  logic                   MEM_W_EN_in,
  input  logic [31:0]            ALU_result_in,
  input  logic [31:0]            ST_val_in,
  output logic                   ready,
  output logic [31:0]            mem_read_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_wdata,
  input  logic [15:0]            sram_rdata,
  output logic                   sram_we_n,
  output logic                   addr_err
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned IDX_W = SRAM_ADDR_W - 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  mem_state_t       state;
  logic             is_store;
  logic [IDX_W-1:0] word_idx;
  logic [15:0]      st_hi;
  logic             req;
  logic             reject;
  logic             accept;
  logic             cnt_load;
  logic             cnt_done;
  logic [31:0]      byte_off;
  logic             unused_bits;

  assign req      = MEM_R_EN_in | MEM_W_EN_in;
  assign byte_off = ALU_result_in - 32'(MEM_BASE);

`ifdef MEM_ALIGN_CHECK_EN
  // A request is refused when misaligned, below the SRAM window, or beyond the
  // last SRAM word; byte_off bits above the index field must all be zero.
  assign reject = req && ((ALU_result_in[1:0] != 2'b00) ||
                          (ALU_result_in < 32'(MEM_BASE)) ||
                          (byte_off[31:IDX_W+2] != '0));
  assign unused_bits = ^byte_off[1:0];
`else
  assign reject      = 1'b0;
  assign unused_bits = ^{byte_off[1:0], byte_off[31:IDX_W+2]};
`endif

  assign accept   = (state == IDLE) && req && !reject;
  assign cnt_load = accept || ((state == LO) && cnt_done);

  sram_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(WAIT_LOAD),
    .done    (cnt_done)
  );

  // In IDLE the pipeline is frozen as soon as a request shows up (unless it is
  // being rejected); DONE releases it for exactly one cycle.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = !req || reject;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Access sequencer. The request is latched in IDLE and only latched values
  // are used afterwards. SRAM outputs are registered and change on the edge
  // that enters LO or HI; read halves are captured on the last cycle of each
  // half-access, when the wait counter reports done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      is_store      <= 1'b0;
      word_idx      <= '0;
      st_hi         <= '0;
      mem_read_data <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_we_n     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_store  <= MEM_W_EN_in;
            word_idx  <= byte_off[IDX_W+1:2];
            st_hi     <= ST_val_in[31:16];
            sram_addr <= {byte_off[IDX_W+1:2], HALF_LO};
            sram_we_n <= !MEM_W_EN_in;
            if (MEM_W_EN_in) begin
              sram_wdata <= ST_val_in[15:0];
            end
            state <= LO;
          end
        end
        LO: begin
          if (cnt_done) begin
            if (!is_store) begin
              mem_read_data[15:0] <= sram_rdata;
            end else begin
              sram_wdata <= st_hi;
            end
            sram_addr <= {word_idx, HALF_HI};
            state     <= HI;
          end
        end
        HI: begin
          if (cnt_done) begin
            if (!is_store) begin
              mem_read_data[31:16] <= sram_rdata;
            end
            sram_we_n <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // One-cycle error pulse following a rejected request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) && reject;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl
// Scoreboard bench: two controllers (WAIT_CYCLES=1 and WAIT_CYCLES=0), each
// with a small behavioural SRAM. Each transaction pushes its hand-computed
// expected response; a per-DUT monitor pops and compares when ready returns.
// Rejection checks run only when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage_sram_ctrl;

  typedef struct {
    int          dut;
    int          lowCycles;
    int          weCycles;
    logic [17:0] addrFirst;
    logic [17:0] addrLast;
    logic [15:0] wdFirst;
    logic [15:0] wdLast;
    logic        isStore;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rEn    [2];
  logic        wEn    [2];
  logic [31:0] aluRes [2];
  logic [31:0] stVal  [2];
  logic        rdy    [2];
  logic [31:0] mData  [2];
  logic [17:0] sAddr  [2];
  logic [15:0] sWdata [2];
  logic [15:0] sRdata [2];
  logic        weN    [2];
  logic        err    [2];

  exp_t expQ [$];
  int   numChecks = 0;
  int   numFails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    numChecks++;
    if (act !== expv) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [15:0] mem [64];
    int          lowCnt;
    int          weCnt;
    logic        busy;
    logic [17:0] addrFirst;
    logic [17:0] addrLast;
    logic [15:0] wdFirst;
    logic [15:0] wdLast;
    exp_t        e;

    mem_stage_sram_ctrl #(
      .SRAM_ADDR_W(18),
      .WAIT_CYCLES((d == 0) ? 1 : 0),
      .MEM_BASE   (1024)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .MEM_R_EN_in  (rEn[d]),
      .MEM_W_EN_in  (wEn[d]),
      .ALU_result_in(aluRes[d]),
      .ST_val_in    (stVal[d]),
      .ready        (rdy[d]),
      .mem_read_data(mData[d]),
      .sram_addr    (sAddr[d]),
      .sram_wdata   (sWdata[d]),
      .sram_rdata   (sRdata[d]),
      .sram_we_n    (weN[d]),
      .addr_err     (err[d])
    );

    // Behavioural SRAM: asynchronous read, write on the clock edge.
    initial begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      if (d == 0) begin
        mem[4] <= 16'hBEEF;
        mem[5] <= 16'hDEAD;
      end else begin
        mem[6] <= 16'h1111;
        mem[7] <= 16'h2222;
      end
    end

    assign sRdata[d] = mem[sAddr[d][5:0]];

    always @(posedge clk) begin
      if (!weN[d]) mem[sAddr[d][5:0]] <= sWdata[d];
    end

    // Monitor: trace a frozen window, then score it when ready comes back.
    initial busy = 1'b0;
    always @(negedge clk) begin
      if (rst) begin
        busy = 1'b0;
      end else if (!rdy[d]) begin
        if (!busy) begin
          busy   = 1'b1;
          lowCnt = 0;
          weCnt  = 0;
        end
        if (lowCnt == 1) begin
          addrFirst = sAddr[d];
          wdFirst   = sWdata[d];
        end
        addrLast = sAddr[d];
        wdLast   = sWdata[d];
        if (!weN[d]) weCnt++;
        lowCnt++;
      end else if (busy) begin
        busy = 1'b0;
        if (expQ.size() == 0) begin
          checkOutput("unexpected completion", 32'(d), 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("completing dut", 32'(d), 32'(e.dut));
          checkOutput("ready low cycles", 32'(lowCnt), 32'(e.lowCycles));
          checkOutput("we_n low cycles", 32'(weCnt), 32'(e.weCycles));
          checkOutput("first half addr", 32'(addrFirst), 32'(e.addrFirst));
          checkOutput("second half addr", 32'(addrLast), 32'(e.addrLast));
          if (e.isStore) begin
            checkOutput("first half wdata", 32'(wdFirst), 32'(e.wdFirst));
            checkOutput("second half wdata", 32'(wdLast), 32'(e.wdLast));
          end
          checkOutput("mem_read_data", mData[d], e.rdata);
          checkOutput("addr_err quiet", 32'(err[d]), 32'd0);
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] stv,
                               input int lowC, input int weC,
                               input logic [17:0] a0, input logic [17:0] a1,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [31:0] rd);
    exp_t x;
    int   n;
    x.dut = d; x.lowCycles = lowC; x.weCycles = weC;
    x.addrFirst = a0; x.addrLast = a1; x.wdFirst = w0; x.wdLast = w1;
    x.isStore = wen; x.rdata = rd;
    expQ.push_back(x);
    @(posedge clk); #1;
    rEn[d] = ren; wEn[d] = wen; aluRes[d] = addr; stVal[d] = stv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy[d] !== 1'b1 && n < 64);
    if (n >= 64) checkOutput("ready timeout", 32'(n), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      rEn[i] = 1'b0;
      wEn[i] = 1'b0;
    end
    repeat (n) @(posedge clk);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic checkReject(input logic [31:0] addr);
    @(posedge clk); #1;
    rEn[0] = 1'b1; wEn[0] = 1'b0; aluRes[0] = addr;
    @(negedge clk);
    checkOutput("reject ready high", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    rEn[0] = 1'b0;
    @(negedge clk);
    checkOutput("addr_err pulse", 32'(err[0]), 32'd1);
    checkOutput("reject we_n", 32'(weN[0]), 32'd1);
    checkOutput("reject ready after", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    checkOutput("addr_err cleared", 32'(err[0]), 32'd0);
    checkOutput("reject data kept", mData[0], 32'h1234_5678);
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rEn[i] = 1'b0; wEn[i] = 1'b0; aluRes[i] = '0; stVal[i] = '0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset ready", 32'(rdy[i]), 32'd1);
      checkOutput("reset mem_read_data", mData[i], 32'd0);
      checkOutput("reset sram_addr", 32'(sAddr[i]), 32'd0);
      checkOutput("reset sram_wdata", 32'(sWdata[i]), 32'd0);
      checkOutput("reset sram_we_n", 32'(weN[i]), 32'd1);
      checkOutput("reset addr_err", 32'(err[i]), 32'd0);
    end
    #13 rst = 1'b0;
    repeat (2) @(posedge clk);

    // W=1 controller: load, then back-to-back store and read-back.
    applyStimulus(0, 1, 0, 32'd1032, 32'h0, 5, 0, 18'd4, 18'd5, 16'h0, 16'h0, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 1, 32'd1024, 32'h1234_5678, 5, 4, 18'd0, 18'd1, 16'h5678, 16'h1234, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 0, 32'd1024, 32'h0, 5, 0, 18'd0, 18'd1, 16'h0, 16'h0, 32'h1234_5678);
`ifndef MEM_ALIGN_CHECK_EN
    applyStimulus(0, 1, 0, 32'd1034, 32'h0, 5, 0, 18'd4, 18'd5, 16'h0, 16'h0, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 0, 32'd525312, 32'h0, 5, 0, 18'd0, 18'd1, 16'h0, 16'h0, 32'h1234_5678);
`endif
    idleCycles(2);

    // W=0 controller: load, store with both enables, read-back.
    applyStimulus(1, 1, 0, 32'd1036, 32'h0, 3, 0, 18'd6, 18'd7, 16'h0, 16'h0, 32'h2222_1111);
    applyStimulus(1, 1, 1, 32'd1028, 32'hA5A5_5A5A, 3, 2, 18'd2, 18'd3, 16'h5A5A, 16'hA5A5, 32'h2222_1111);
    applyStimulus(1, 1, 0, 32'd1028, 32'h0, 3, 0, 18'd2, 18'd3, 16'h0, 16'h0, 32'hA5A5_5A5A);
    idleCycles(2);

`ifdef MEM_ALIGN_CHECK_EN
    checkReject(32'd1025);
    checkReject(32'd1020);
    checkReject(32'd525312);
    idleCycles(1);
`endif

    // Reset during the HI half of a store on the W=1 controller.
    @(posedge clk); #1;
    rEn[0] = 1'b0; wEn[0] = 1'b1; aluRes[0] = 32'd1040; stVal[0] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("HI store we_n", 32'(weN[0]), 32'd0);
    checkOutput("HI store addr", 32'(sAddr[0]), 32'd9);
    rst = 1'b1;
    wEn[0] = 1'b0;
    #1;
    checkOutput("abort we_n", 32'(weN[0]), 32'd1);
    checkOutput("abort ready", 32'(rdy[0]), 32'd1);
    checkOutput("abort mem_read_data", mData[0], 32'd0);
    checkOutput("abort sram_addr", 32'(sAddr[0]), 32'd0);
    checkOutput("abort other dut data", mData[1], 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    // Only the low half reached the SRAM before the abort.
    applyStimulus(0, 1, 0, 32'd1040, 32'h0, 5, 0, 18'd8, 18'd9, 16'h0, 16'h0, 32'h0000_F00D);
    idleCycles(3);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
